// File: rtl/mips_mc_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/write-back,
// drives datapath enables and mux selects, and counts retired instructions.
module mips_mc_control_fsm #(
  parameter int OP_W          = 6,
  parameter int FUNCT_W       = 6,
  parameter int ALUCTRL_W     = 4,
  parameter int CNT_W         = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      op,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 branch_eq,
  output logic                 branch_ne,
  output logic                 ir_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 iord,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 ext_zero,
  output logic [1:0]           pc_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 instr_done,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     instr_count
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC += 4 when memory is ready
  // DECODE   | decode op/funct, precompute branch target into ALUOut
  // EXE_R    | R-type ALU operation
  // EXE_I    | immediate ALU operation
  // ALU_WB   | write ALU result to register file
  // MEM_ADR  | compute load/store address
  // MEM_RD   | load data read, waits for mem_ready
  // MEM_WB   | write loaded data to register file
  // MEM_WR   | store data write, waits for mem_ready
  // BRANCH   | compare operands, conditional PC load from ALUOut
  // JUMP     | load PC with jump target
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXE_R, S_EXE_I, S_ALU_WB, S_MEM_ADR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(8);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(43);

  localparam logic [FUNCT_W-1:0] F_SLL = FUNCT_W'(0);
  localparam logic [FUNCT_W-1:0] F_SRL = FUNCT_W'(2);
  localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(32);
  localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(34);
  localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(36);
  localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(37);
  localparam logic [FUNCT_W-1:0] F_SLT = FUNCT_W'(42);

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_LUI = ALUCTRL_W'(14);

  state_t                 state, state_next;
  logic                   mem_rdy;
  logic                   r_legal, r_shift;
  logic [ALUCTRL_W-1:0]   r_alu, i_alu;
  logic                   i_legal, i_zext;

  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    r_legal = 1'b1;
    r_shift = 1'b0;
    r_alu   = ALU_ADD;
    case (funct)
      F_ADD: r_alu = ALU_ADD;
      F_SUB: r_alu = ALU_SUB;
      F_AND: r_alu = ALU_AND;
      F_OR:  r_alu = ALU_OR;
      F_SLT: r_alu = ALU_SLT;
      F_SLL: begin r_alu = ALU_SLL; r_shift = 1'b1; end
      F_SRL: begin r_alu = ALU_SRL; r_shift = 1'b1; end
      default: r_legal = 1'b0;
    endcase
  end

  always_comb begin
    i_legal = 1'b1;
    i_zext  = 1'b0;
    i_alu   = ALU_ADD;
    case (op)
      OP_ADDI: i_alu = ALU_ADD;
      OP_ANDI: begin i_alu = ALU_AND; i_zext = 1'b1; end
      OP_ORI:  begin i_alu = ALU_OR;  i_zext = 1'b1; end
      OP_LUI:  i_alu = ALU_LUI;
      default: i_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             instr_count <= '0;
    else if (instr_done) instr_count <= instr_count + CNT_W'(1);
  end

  always_comb begin
    state_next  = state;
    pc_write    = 1'b0;
    branch_eq   = 1'b0;
    branch_ne   = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    ext_zero    = 1'b0;
    pc_src      = 2'd0;
    alu_control = ALU_ADD;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_rdy) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        if (op == OP_R && r_legal)        state_next = S_EXE_R;
        else if (i_legal)                 state_next = S_EXE_I;
        else if (op == OP_LW || op == OP_SW)   state_next = S_MEM_ADR;
        else if (op == OP_BEQ || op == OP_BNE) state_next = S_BRANCH;
        else if (op == OP_J)              state_next = S_JUMP;
        else begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXE_R: begin
        alu_src_a   = r_shift ? 2'd2 : 2'd1;
        alu_control = r_alu;
        state_next  = S_ALU_WB;
      end
      S_EXE_I: begin
        alu_src_a   = 2'd1;
        alu_src_b   = 2'd2;
        alu_control = i_alu;
        ext_zero    = i_zext;
        state_next  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op == OP_R);
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_ADR: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        state_next = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_rdy) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_rdy) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a   = 2'd1;
        alu_control = ALU_SUB;
        pc_src      = 2'd1;
        branch_eq   = (op == OP_BEQ);
        branch_ne   = (op == OP_BNE);
        instr_done  = 1'b1;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset forces every control low immediately so an in-flight write is dropped.
    if (rst) begin
      pc_write    = 1'b0;
      branch_eq   = 1'b0;
      branch_ne   = 1'b0;
      ir_write    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 2'd0;
      alu_src_b   = 2'd0;
      ext_zero    = 1'b0;
      pc_src      = 2'd0;
      alu_control = ALU_ADD;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// Self-checking bench: per-cycle expected control vectors are queued as stimulus
// is driven and compared against the DUT outputs at the falling edge.
module tb_mips_mc_control_fsm;

  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       mem_ready;
  logic       pc_write, branch_eq, branch_ne, ir_write, mem_read, mem_write, iord;
  logic       reg_write, reg_dst, mem_to_reg, ext_zero, instr_done, illegal_op;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic [3:0] alu_control;
  logic [CNT_W-1:0] instr_count;

  typedef struct packed {
    logic       pc_write, branch_eq, branch_ne, ir_write, mem_read, mem_write, iord;
    logic       reg_write, reg_dst, mem_to_reg;
    logic [1:0] alu_src_a, alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_src;
    logic [3:0] alu_control;
    logic       instr_done, illegal_op;
  } ctl_t;

  ctl_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  mips_mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .pc_src(pc_src), .alu_control(alu_control), .instr_done(instr_done),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic ctl_t got_ctl();
    return '{pc_write, branch_eq, branch_ne, ir_write, mem_read, mem_write, iord,
             reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero,
             pc_src, alu_control, instr_done, illegal_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // expected control vectors for each state
  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t c = '0;
    c.mem_read = 1; c.alu_src_b = 2'd1; c.ir_write = rdy; c.pc_write = rdy;
    return c;
  endfunction
  function automatic ctl_t e_decode();
    ctl_t c = '0;
    c.alu_src_b = 2'd3;
    return c;
  endfunction
  function automatic ctl_t e_illegal();
    ctl_t c = e_decode();
    c.illegal_op = 1; c.instr_done = 1;
    return c;
  endfunction
  function automatic ctl_t e_exe_r(input logic [3:0] ac, input logic sh);
    ctl_t c = '0;
    c.alu_src_a = sh ? 2'd2 : 2'd1; c.alu_control = ac;
    return c;
  endfunction
  function automatic ctl_t e_exe_i(input logic [3:0] ac, input logic ez);
    ctl_t c = '0;
    c.alu_src_a = 2'd1; c.alu_src_b = 2'd2; c.alu_control = ac; c.ext_zero = ez;
    return c;
  endfunction
  function automatic ctl_t e_alu_wb(input logic rd);
    ctl_t c = '0;
    c.reg_write = 1; c.reg_dst = rd; c.instr_done = 1;
    return c;
  endfunction
  function automatic ctl_t e_mem_adr();
    ctl_t c = '0;
    c.alu_src_a = 2'd1; c.alu_src_b = 2'd2;
    return c;
  endfunction
  function automatic ctl_t e_mem_rd();
    ctl_t c = '0;
    c.mem_read = 1; c.iord = 1;
    return c;
  endfunction
  function automatic ctl_t e_mem_wb();
    ctl_t c = '0;
    c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1;
    return c;
  endfunction
  function automatic ctl_t e_mem_wr(input logic rdy);
    ctl_t c = '0;
    c.mem_write = 1; c.iord = 1; c.instr_done = rdy;
    return c;
  endfunction
  function automatic ctl_t e_branch(input logic [5:0] o);
    ctl_t c = '0;
    c.alu_src_a = 2'd1; c.alu_control = 4'd1; c.pc_src = 2'd1; c.instr_done = 1;
    c.branch_eq = (o == 6'd4); c.branch_ne = (o == 6'd5);
    return c;
  endfunction
  function automatic ctl_t e_jump();
    ctl_t c = '0;
    c.pc_write = 1; c.pc_src = 2'd2; c.instr_done = 1;
    return c;
  endfunction

  // One clock: drive mem_ready, queue the expectation, compare at the falling edge.
  task automatic step(input string tag, input logic rdy, input ctl_t exp);
    ctl_t e;
    mem_ready = rdy;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(tag, 32'(got_ctl()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string tag);
    chk(tag, 32'(instr_count), 32'(exp_cnt % (1 << CNT_W)));
  endtask

  task automatic run_r(input logic [5:0] f, input logic [3:0] ac, input logic sh);
    op = 6'd0; funct = f;
    step("r_fetch", 1, e_fetch(1));
    step("r_decode", 1, e_decode());
    step("r_exe", 1, e_exe_r(ac, sh));
    step("r_wb", 1, e_alu_wb(1));
    exp_cnt++;
    check_count("r_count");
  endtask

  task automatic run_i(input logic [5:0] o, input logic [3:0] ac, input logic ez);
    op = o; funct = 6'd17;
    step("i_fetch", 1, e_fetch(1));
    step("i_decode", 1, e_decode());
    step("i_exe", 1, e_exe_i(ac, ez));
    step("i_wb", 1, e_alu_wb(0));
    exp_cnt++;
    check_count("i_count");
  endtask

  task automatic run_lw(input int fetch_waits, input int rd_waits);
    op = 6'd35; funct = 6'd0;
    for (int i = 0; i < fetch_waits; i++) step("lw_fetch_wait", 0, e_fetch(0));
    step("lw_fetch", 1, e_fetch(1));
    step("lw_decode", 1, e_decode());
    step("lw_adr", 1, e_mem_adr());
    for (int i = 0; i < rd_waits; i++) step("lw_rd_wait", 0, e_mem_rd());
    step("lw_rd", 1, e_mem_rd());
    step("lw_wb", 1, e_mem_wb());
    exp_cnt++;
    check_count("lw_count");
  endtask

  task automatic run_sw(input int wr_waits);
    op = 6'd43; funct = 6'd0;
    step("sw_fetch", 1, e_fetch(1));
    step("sw_decode", 1, e_decode());
    step("sw_adr", 1, e_mem_adr());
    for (int i = 0; i < wr_waits; i++) step("sw_wr_wait", 0, e_mem_wr(0));
    step("sw_wr", 1, e_mem_wr(1));
    exp_cnt++;
    check_count("sw_count");
  endtask

  task automatic run_br(input logic [5:0] o);
    op = o; funct = 6'd42;
    step("br_fetch", 1, e_fetch(1));
    step("br_decode", 1, e_decode());
    step("br_exec", 1, e_branch(o));
    exp_cnt++;
    check_count("br_count");
  endtask

  task automatic run_j();
    op = 6'd2; funct = 6'd0;
    step("j_fetch", 1, e_fetch(1));
    step("j_decode", 1, e_decode());
    step("j_exec", 1, e_jump());
    exp_cnt++;
  endtask

  task automatic run_ill(input logic [5:0] o, input logic [5:0] f);
    op = o; funct = f;
    step("ill_fetch", 1, e_fetch(1));
    step("ill_decode", 1, e_illegal());
    exp_cnt++;
    check_count("ill_count");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; op = '0; funct = '0; mem_ready = 1'b1;
    #2;
    chk("reset_ctl", 32'(got_ctl()), 32'(0));
    chk("reset_count", 32'(instr_count), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_r(6'd34, 4'd1, 0);
    run_r(6'd32, 4'd0, 0);
    run_r(6'd36, 4'd2, 0);
    run_r(6'd37, 4'd3, 0);
    run_r(6'd42, 4'd4, 0);
    run_r(6'd0,  4'd5, 1);
    run_r(6'd2,  4'd6, 1);
    run_lw(0, 2);
    run_lw(1, 0);
    run_sw(0);
    run_br(6'd5);
    run_br(6'd4);
    run_ill(6'd63, 6'd0);
    run_ill(6'd0, 6'd1);
    run_i(6'd13, 4'd3, 1);
    run_i(6'd12, 4'd2, 1);
    run_i(6'd8,  4'd0, 0);
    run_i(6'd15, 4'd14, 0);

    // reset in the middle of a stalled store
    op = 6'd43;
    step("rs_fetch", 1, e_fetch(1));
    step("rs_decode", 1, e_decode());
    step("rs_adr", 1, e_mem_adr());
    step("rs_wr_wait", 0, e_mem_wr(0));
    rst = 1'b1;
    #1;
    chk("mid_reset_ctl", 32'(got_ctl()), 32'(0));
    chk("mid_reset_count", 32'(instr_count), 32'(0));
    exp_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    mem_ready = 1'b1;
    step("post_reset_fetch", 1, e_fetch(1));
    step("post_reset_decode", 1, e_decode());
    step("post_reset_adr", 1, e_mem_adr());
    step("post_reset_wr", 1, e_mem_wr(1));
    exp_cnt++;
    check_count("post_reset_count");

    // count from a fresh reset so 17 jumps leave exactly 1 in a 4-bit counter
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 17; i++) run_j();
    chk("wrap_count", 32'(instr_count), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_control_fsm.md
Name:
mips_mc_control_fsm

Overview:
Parametrised next-generation control unit for the multicycle MIPS datapath. It decodes Op/Funct and sequences fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select, plus the ALU control code. Compared with the first-generation unit it adds:
- lw, beq, j, srl and the full R-type ALU set
- a memory ready handshake
- illegal-opcode detection
- a retired-instruction counter

Parameters:
OP_W, 6, opcode width
FUNCT_W, 6, funct width
ALUCTRL_W, 4, ALU control width
CNT_W, 32, retired-instruction counter width
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
op  in  OP_W  instruction opcode (from IR)
funct  in  FUNCT_W  instruction funct (from IR)
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
branch_eq  out  1  PC load if ALU zero
branch_ne  out  1  PC load if ALU not zero
ir_write  out  1  IR load
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  address select: 0 = PC, 1 = ALUOut
reg_write  out  1  register file write
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = memory data
alu_src_a  out  2  0 = PC, 1 = reg A, 2 = shamt
alu_src_b  out  2  0 = reg B, 1 = const 4, 2 = extended imm, 3 = sign-ext imm<<2
ext_zero  out  1  1 = zero-extend imm (andi/ori)
pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
alu_control  out  ALUCTRL_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 14 LUI
instr_done  out  1  one-cycle pulse in the last cycle of every instruction
illegal_op  out  1  one-cycle pulse on an unsupported op/funct
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset is asynchronous and active-high.
  - While rst = 1: state = FETCH, instr_count = 0, every control output forced to 0.
  - After rst falls, the first clock cycle already drives FETCH outputs.
  - rst asserted mid-instruction aborts immediately; no pending write completes.
- All outputs not listed for a state are 0. alu_control defaults to ADD.
- FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, ADD, pc_src = 0.
  - ir_write and pc_write = 1 only in a cycle where mem_ready = 1; that cycle moves to DECODE.
  - If mem_ready = 0, stay in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 3, ADD (precomputes the branch target into ALUOut). Next state by op:
  - op 0 with funct 32/34/36/37/42/0/2 -> EXE_R
  - op 8/12/13/15 -> EXE_I
  - op 35/43 -> MEM_ADR
  - op 4/5 -> BRANCH
  - op 2 -> JUMP
  - any other op/funct -> FETCH, with illegal_op = 1 and instr_done = 1
- EXE_R: drives the ALU by funct.
  - add ADD, sub SUB, and AND, or OR, slt SLT: alu_src_a = 1, alu_src_b = 0.
  - sll SLL, srl SRL: alu_src_a = 2, alu_src_b = 0.
  - Next state ALU_WB.
- EXE_I: alu_src_a = 1, alu_src_b = 2.
  - addi ADD; andi AND with ext_zero; ori OR with ext_zero; lui LUI.
  - Next state ALU_WB.
- ALU_WB: reg_write = 1, mem_to_reg = 0, reg_dst = 1 only for op 0, instr_done = 1. Next state FETCH.
- MEM_ADR: alu_src_a = 1, alu_src_b = 2, ADD. Next state MEM_RD if op = 35, else MEM_WR.
- MEM_RD: mem_read = 1, iord = 1. Advance to MEM_WB on mem_ready.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1. Next state FETCH.
- MEM_WR: mem_write = 1, iord = 1; hold until mem_ready. In the mem_ready cycle instr_done = 1 and the next state is FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, SUB, pc_src = 1, instr_done = 1. Next state FETCH.
  - branch_eq = 1 for op 4; branch_ne = 1 for op 5.
- JUMP: pc_write = 1, pc_src = 2, instr_done = 1. Next state FETCH.
- Cycle counts with mem_ready held high: R-type 4, I-ALU 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2. Each wait cycle adds 1.
- instr_count increments on each instr_done, including illegal ops. It wraps modulo 2^CNT_W.
- op and funct are sampled combinationally. They must stay stable from DECODE until the instruction ends, because IR is not written again until the next FETCH.
- Undefined state encodings go to FETCH.

Test Plan:
- Reset: assert rst mid-MEM_WR with mem_write = 1 -> mem_write drops asynchronously, outputs all 0; after release FETCH asserts mem_read = 1, and instr_count = 0.
- R-type: mem_ready = 1, op = 0, funct = 34 -> exactly 4 cycles; EXE_R drives alu_control = 1; ALU_WB drives reg_write = 1 and reg_dst = 1; instr_done pulses once.
- lw with a wait: op = 35, mem_ready low for 2 cycles during MEM_RD -> 7 cycles total; MEM_WB drives mem_to_reg = 1 and reg_write = 1; no reg_write in any earlier cycle.
- Branch: op = 5 -> 3 cycles, with branch_ne = 1, branch_eq = 0, pc_src = 1, alu_control = 1. Repeat with op = 4 -> branch_eq = 1.
- Illegal and ori: op = 63 -> illegal_op pulses in DECODE and the unit returns to FETCH. Then op = 13 -> ext_zero = 1, alu_control = 3, reg_dst = 0.
- Counter wrap: CNT_W = 4, run 17 jumps (op = 2) -> instr_count = 1; each jump asserts pc_write with pc_src = 2.
